// File: rtl/raster_core_multirow.sv
// raster_core_multirow
//   Scanline rasteriser core owning NUM_ROWS consecutive scanlines
//   (global rows CORE_ID*NUM_ROWS .. CORE_ID*NUM_ROWS+NUM_ROWS-1). A
//   {triangle id, depth} line buffer lives in an external simple-dual-port
//   BRAM. Triangles arrive as 10-word packets; covered pixels are
//   depth-tested and written. An end packet streams the id buffer out
//   and clears it.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   s_valid/s_data/s_ready triangle packet stream (32-bit words)
//   m_valid/m_ready        writeback stream handshake
//   m_data                 {global_row[3:0], id[11:0]}
//   m_last                 final writeback beat
//   rch_en/rch_addr        BRAM read port, rch_data valid BRAM_LATENCY later
//   rch_data               BRAM read data {4'b0, id, z}
//   wch_en/wch_addr        BRAM write port
//   wch_data               BRAM write data {4'b0, id, z}
module raster_core_multirow #(
   parameter int unsigned CORE_ID      = 0,
   parameter int unsigned NUM_ROWS     = 2,
   parameter int unsigned X_MAX        = 400,
   parameter int unsigned BRAM_LATENCY = 2,
   parameter logic [31:0] LAMBDA_ONE   = 32'h0001_0000,
   parameter int unsigned ADDR_W       = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   input  logic [31:0]       s_data,
   output logic              s_ready,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [15:0]       m_data,
   output logic              m_last,
   output logic              rch_en,
   output logic [ADDR_W-1:0] rch_addr,
   input  logic [31:0]       rch_data,
   output logic              wch_en,
   output logic [ADDR_W-1:0] wch_addr,
   output logic [31:0]       wch_data
);

   localparam int unsigned NPIX     = NUM_ROWS * X_MAX;
   localparam int unsigned ROW_BASE = CORE_ID * NUM_ROWS;
   localparam int unsigned XW       = $clog2(X_MAX + BRAM_LATENCY + 2);
   localparam int unsigned RW       = $clog2(NUM_ROWS + 1);
   localparam int unsigned CW       = $clog2(BRAM_LATENCY + 1);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_PREP,
      S_RASTER,
      S_WB_WAIT,
      S_WB_OUT
   } state_t;

   state_t            state_q;
   logic [3:0]        wcnt_q;
   logic [5:0]        y_start_q, y_end_q;
   logic              end_q;
   logic [11:0]       id_q;
   logic [31:0]       l0_q, l1_q, l0dx_q, l0dy_q, l1dx_q, l1dy_q;
   logic [15:0]       z0_q, zdx_q, zdy_q;
   logic [RW-1:0]     r_q;
   logic [XW-1:0]     x_q;
   logic [ADDR_W-1:0] a_q;
   logic [CW-1:0]     cnt_q;
   logic [31:0]       lam0_q, lam1_q;
   logic [15:0]       zacc_q;
   logic [ADDR_W-1:0] rbase_q;

   logic              s_ready_q, m_valid_q, m_last_q;
   logic [15:0]       m_data_q;
   logic              rch_en_q, wch_en_q;
   logic [ADDR_W-1:0] rch_addr_q, wch_addr_q;
   logic [31:0]       wch_data_q;

   logic [31:0]       gy_d, first_r_d;
   logic              first_ok_d, next_ok_d;
   logic [32:0]       lam_sum_d;
   logic              inside_d, eval_d, wr_hit_d;
   logic [ADDR_W-1:0] pix_addr_d;
   logic              unused_d;

   assign s_ready  = s_ready_q;
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_last   = m_last_q;
   assign rch_en   = rch_en_q;
   assign rch_addr = rch_addr_q;
   assign wch_en   = wch_en_q;
   assign wch_addr = wch_addr_q;
   assign wch_data = wch_data_q;

   assign unused_d = ^{rch_data[31:28], s_data[19:13]};

   always_comb begin
      gy_d      = 32'(ROW_BASE) + 32'(r_q);
      // Owned rows are contiguous, so the first covered one is simply
      // max(y_start, ROW_BASE) provided it is still owned and <= y_end.
      first_r_d = '0;
      if (32'(y_start_q) > 32'(ROW_BASE))
         first_r_d = 32'(y_start_q) - 32'(ROW_BASE);
      first_ok_d = (first_r_d < NUM_ROWS) &&
                   ((32'(ROW_BASE) + first_r_d) <= 32'(y_end_q));
      next_ok_d  = ((32'(r_q) + 32'd1) < NUM_ROWS) &&
                   ((gy_d + 32'd1) <= 32'(y_end_q));
      lam_sum_d  = {lam0_q[31], lam0_q} + {lam1_q[31], lam1_q};
      inside_d   = !lam0_q[31] && !lam1_q[31] &&
                   ($signed(lam_sum_d) <= $signed({1'b0, LAMBDA_ONE}));
      // The read for pixel p leaves the register stage one cycle after it is
      // scheduled, so its data is back at x_q = p + BRAM_LATENCY + 1.
      eval_d     = x_q >= XW'(BRAM_LATENCY + 1);
      wr_hit_d   = eval_d && inside_d && (zacc_q > rch_data[15:0]);
      pix_addr_d = rbase_q + ADDR_W'(x_q) - ADDR_W'(BRAM_LATENCY + 1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_CLEAR;
         wcnt_q     <= '0;
         y_start_q  <= '0;
         y_end_q    <= '0;
         end_q      <= 1'b0;
         id_q       <= '0;
         l0_q       <= '0;
         l1_q       <= '0;
         l0dx_q     <= '0;
         l0dy_q     <= '0;
         l1dx_q     <= '0;
         l1dy_q     <= '0;
         z0_q       <= '0;
         zdx_q      <= '0;
         zdy_q      <= '0;
         r_q        <= '0;
         x_q        <= '0;
         a_q        <= '0;
         cnt_q      <= '0;
         lam0_q     <= '0;
         lam1_q     <= '0;
         zacc_q     <= '0;
         rbase_q    <= '0;
         s_ready_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
         rch_en_q   <= 1'b0;
         rch_addr_q <= '0;
         wch_en_q   <= 1'b0;
         wch_addr_q <= '0;
         wch_data_q <= '0;
      end else begin
         rch_en_q <= 1'b0;
         wch_en_q <= 1'b0;
         case (state_q)
            S_CLEAR: begin
               wch_en_q   <= 1'b1;
               wch_addr_q <= a_q;
               wch_data_q <= '0;
               if (a_q == ADDR_W'(NPIX - 1)) begin
                  a_q     <= '0;
                  state_q <= S_IDLE;
               end else begin
                  a_q <= a_q + ADDR_W'(1);
               end
            end

            S_IDLE: begin
               s_ready_q <= 1'b1;
               if (s_valid && s_ready_q) begin
                  case (wcnt_q)
                     4'd0: begin
                        y_start_q <= s_data[5:0];
                        y_end_q   <= s_data[11:6];
                        end_q     <= s_data[12];
                        id_q      <= s_data[31:20];
                     end
                     4'd1:    l0_q   <= s_data;
                     4'd2:    l1_q   <= s_data;
                     4'd3:    l0dx_q <= s_data;
                     4'd4:    l0dy_q <= s_data;
                     4'd5:    l1dx_q <= s_data;
                     4'd6:    l1dy_q <= s_data;
                     4'd7:    z0_q   <= s_data[15:0];
                     4'd8:    zdx_q  <= s_data[15:0];
                     default: zdy_q  <= s_data[15:0];
                  endcase
                  if (wcnt_q == 4'd9) begin
                     wcnt_q    <= '0;
                     s_ready_q <= 1'b0;
                     if (end_q) begin
                        a_q        <= '0;
                        x_q        <= '0;
                        r_q        <= '0;
                        cnt_q      <= '0;
                        rch_en_q   <= 1'b1;
                        rch_addr_q <= '0;
                        state_q    <= S_WB_WAIT;
                     end else if (first_ok_d) begin
                        r_q     <= RW'(first_r_d);
                        state_q <= S_PREP;
                     end
                  end else begin
                     wcnt_q <= wcnt_q + 4'd1;
                  end
               end
            end

            S_PREP: begin
               lam0_q  <= l0_q + l0dy_q * gy_d;
               lam1_q  <= l1_q + l1dy_q * gy_d;
               zacc_q  <= z0_q + zdy_q * gy_d[15:0];
               rbase_q <= ADDR_W'(32'(r_q) * X_MAX);
               x_q     <= '0;
               state_q <= S_RASTER;
            end

            S_RASTER: begin
               rch_en_q   <= x_q < XW'(X_MAX);
               rch_addr_q <= rbase_q + ADDR_W'(x_q);
               if (eval_d) begin
                  wch_en_q   <= wr_hit_d;
                  wch_addr_q <= pix_addr_d;
                  wch_data_q <= {4'b0, id_q, zacc_q};
                  lam0_q     <= lam0_q + l0dx_q;
                  lam1_q     <= lam1_q + l1dx_q;
                  zacc_q     <= zacc_q + zdx_q;
               end
               if (x_q == XW'(X_MAX + BRAM_LATENCY)) begin
                  if (next_ok_d) begin
                     r_q     <= r_q + RW'(1);
                     state_q <= S_PREP;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  x_q <= x_q + XW'(1);
               end
            end

            S_WB_WAIT: begin
               if (cnt_q == CW'(BRAM_LATENCY)) begin
                  m_valid_q <= 1'b1;
                  m_data_q  <= {gy_d[3:0], rch_data[27:16]};
                  m_last_q  <= a_q == ADDR_W'(NPIX - 1);
                  state_q   <= S_WB_OUT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_WB_OUT: begin
               if (m_ready) begin
                  // Clearing a and issuing the read of a+1 share this edge,
                  // giving the BRAM_LATENCY+2 cycle beat period.
                  m_valid_q  <= 1'b0;
                  m_last_q   <= 1'b0;
                  wch_en_q   <= 1'b1;
                  wch_addr_q <= a_q;
                  wch_data_q <= '0;
                  if (a_q == ADDR_W'(NPIX - 1)) begin
                     a_q     <= '0;
                     x_q     <= '0;
                     r_q     <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     a_q        <= a_q + ADDR_W'(1);
                     rch_en_q   <= 1'b1;
                     rch_addr_q <= a_q + ADDR_W'(1);
                     cnt_q      <= '0;
                     if (x_q == XW'(X_MAX - 1)) begin
                        x_q <= '0;
                        r_q <= r_q + RW'(1);
                     end else begin
                        x_q <= x_q + XW'(1);
                     end
                     state_q <= S_WB_WAIT;
                  end
               end
            end

            default: state_q <= S_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_raster_core_multirow.sv
module tb_raster_core_multirow;

   localparam int unsigned BL = 2;

   typedef struct {
      logic [5:0]  ys;
      logic [5:0]  ye;
      logic        endf;
      logic [11:0] id;
      logic [31:0] l0;
      logic [31:0] l1;
      logic [31:0] l0dx;
      logic [31:0] l0dy;
      logic [31:0] l1dx;
      logic [31:0] l1dy;
      logic [15:0] z0;
      logic [15:0] zdx;
      logic [15:0] zdy;
      int          exp_wr;
      int          exp_rd;
      logic [15:0] exp_mask;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_last;
   logic        rch_en;
   logic [9:0]  rch_addr;
   logic [31:0] rch_data;
   logic        wch_en;
   logic [9:0]  wch_addr;
   logic [31:0] wch_data;

   int tests = 0;
   int fails = 0;

   vec_t        vecs [6];
   vec_t        endv;
   logic [31:0] pkt [10];

   always #5 clk = ~clk;

   raster_core_multirow #(
      .CORE_ID      (3),
      .NUM_ROWS     (2),
      .X_MAX        (8),
      .BRAM_LATENCY (BL),
      .LAMBDA_ONE   (32'h0001_0000),
      .ADDR_W       (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last),
      .rch_en   (rch_en),
      .rch_addr (rch_addr),
      .rch_data (rch_data),
      .wch_en   (wch_en),
      .wch_addr (wch_addr),
      .wch_data (wch_data)
   );

   // BRAM model plus access counters
   logic [31:0] mem [16];
   logic [31:0] rd_pipe [BL];
   int unsigned wr_total = 0;
   int unsigned rd_total = 0;
   int unsigned hits [16] = '{default: 0};

   always @(posedge clk) begin
      if (wch_en && wch_addr < 10'd16) begin
         mem[wch_addr[3:0]]  <= wch_data;
         hits[wch_addr[3:0]] <= hits[wch_addr[3:0]] + 1;
      end
      if (wch_en) wr_total <= wr_total + 1;
      if (rch_en) rd_total <= rd_total + 1;
      if (rch_en && rch_addr < 10'd16) rd_pipe[0] <= mem[rch_addr[3:0]];
      else rd_pipe[0] <= 32'hDEAD_DEAD;
      for (int i = 1; i < BL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign rch_data = rd_pipe[BL-1];

   task automatic chk(input bit ok, input string name,
                      input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic build_pkt(input vec_t v);
      pkt[0] = {v.id, 7'b0, v.endf, v.ye, v.ys};
      pkt[1] = v.l0;
      pkt[2] = v.l1;
      pkt[3] = v.l0dx;
      pkt[4] = v.l0dy;
      pkt[5] = v.l1dx;
      pkt[6] = v.l1dy;
      pkt[7] = {16'h0, v.z0};
      pkt[8] = {16'h0, v.zdx};
      pkt[9] = {16'h0, v.zdy};
   endtask

   // Called at #1 after an edge; returns at #1 after the last transfer edge.
   task automatic send_pkt(input string name);
      int waits;
      int gaps = 0;
      int tmo  = 0;
      for (int k = 0; k < 10; k++) begin
         s_valid = 1'b1;
         s_data  = pkt[k];
         waits   = 0;
         while (!s_ready && waits < 100) begin
            @(posedge clk); #1;
            waits++;
         end
         if (waits >= 100) tmo++;
         if (k > 0 && waits > 0) gaps++;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_data  = 32'h0;
      chk(gaps == 0 && tmo == 0, name, 32'(gaps + tmo), 32'h0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!s_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk(s_ready == 1'b1, name, 32'(s_ready), 32'h1);
   endtask

   task automatic reset_and_clear(input string name);
      int bad = 0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk(!m_valid && !m_last && !rch_en && !wch_en && !s_ready, name,
          {27'h0, m_valid, m_last, rch_en, wch_en, s_ready}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (!(wch_en && 32'(wch_addr) == i && wch_data == 32'h0 && !s_ready && !rch_en))
            bad++;
      end
      chk(bad == 0, "clear_seq", 32'(bad), 32'h0);
      @(posedge clk); #1;
      chk(s_ready && !wch_en, "clear_sready", {30'h0, s_ready, wch_en}, 32'h2);
   endtask

   task automatic run_vec(input int idx);
      int unsigned snap [16];
      int unsigned wr0, rd0;
      logic [15:0] mask;
      logic [31:0] e;
      wr0 = wr_total;
      rd0 = rd_total;
      for (int a = 0; a < 16; a++) snap[a] = hits[a];
      build_pkt(vecs[idx]);
      send_pkt("vec_accept");
      wait_idle("vec_idle");
      chk(int'(wr_total - wr0) == vecs[idx].exp_wr, "vec_wr_count",
          32'(wr_total - wr0), 32'(vecs[idx].exp_wr));
      chk(int'(rd_total - rd0) == vecs[idx].exp_rd, "vec_rd_count",
          32'(rd_total - rd0), 32'(vecs[idx].exp_rd));
      mask = 16'h0;
      for (int a = 0; a < 16; a++) mask[a] = hits[a] != snap[a];
      chk(mask == vecs[idx].exp_mask, "vec_wr_mask", 32'(mask), 32'(vecs[idx].exp_mask));
      for (int a = 0; a < 16; a++) begin
         if (vecs[idx].exp_mask[a]) begin
            e = (a < 8) ? vecs[idx].d0 : vecs[idx].d1;
            chk(mem[a] == e, "vec_wr_data", mem[a], e);
         end
      end
   endtask

   task automatic writeback_run();
      int          beats = 0;
      int          cyc   = 0;
      int          extra = 0;
      int          n     = 0;
      logic        stall_prev = 1'b0;
      logic [15:0] pd = 16'h0;
      logic        pl = 1'b0;
      logic [15:0] e;
      m_ready = 1'b0;
      build_pkt(endv);
      send_pkt("wb_accept");
      while (beats < 16 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
         m_ready = (cyc % 3) != 2;
         if (stall_prev)
            chk(m_valid && m_data == pd && m_last == pl, "wb_hold",
                {15'h0, m_valid, m_last, m_data}, {15'h0, 1'b1, pl, pd});
         if (m_valid && m_ready) begin
            e = (beats == 0) ? 16'h6123 : (beats < 8) ? 16'h6ABC : 16'h7000;
            chk(m_data == e, "wb_data", 32'(m_data), 32'(e));
            chk(m_last == (beats == 15), "wb_last", 32'(m_last), 32'(beats == 15));
            beats++;
         end
         stall_prev = m_valid && !m_ready;
         pd = m_data;
         pl = m_last;
      end
      chk(beats == 16, "wb_beats", 32'(beats), 32'd16);
      while (!s_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (m_valid) extra++;
      end
      m_ready = 1'b0;
      chk(s_ready && extra == 0, "wb_end", 32'(extra), 32'h0);
      for (int a = 0; a < 16; a++) chk(mem[a] == 32'h0, "wb_cleared", mem[a], 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{6'd6, 6'd6, 1'b0, 12'hABC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  16'd5, 16'h0, 16'h0, 8, 8, 16'h00FF, 32'h0ABC_0005, 32'h0};
      vecs[1] = '{6'd6, 6'd6, 1'b0, 12'hABC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  16'd5, 16'h0, 16'h0, 0, 8, 16'h0000, 32'h0, 32'h0};
      vecs[2] = '{6'd6, 6'd6, 1'b0, 12'hABC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  16'd3, 16'h0, 16'h0, 0, 8, 16'h0000, 32'h0, 32'h0};
      vecs[3] = '{6'd6, 6'd6, 1'b0, 12'h123, 32'h0, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0,
                  16'd9, 16'h0, 16'h0, 1, 8, 16'h0001, 32'h0123_0009, 32'h0};
      vecs[4] = '{6'd10, 6'd12, 1'b0, 12'h777, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  16'd9, 16'h0, 16'h0, 0, 0, 16'h0000, 32'h0, 32'h0};
      // Both rows; L1 starts 2/1 below unity and crosses it by one step per pixel
      vecs[5] = '{6'd0, 6'd7, 1'b0, 12'h055, 32'h0, 32'h0000_FFF8, 32'h0, 32'h0, 32'h1, 32'h1,
                  16'h0010, 16'h0, 16'h1, 5, 16, 16'h0307, 32'h0055_0016, 32'h0055_0017};
      endv    = '{6'd0, 6'd0, 1'b1, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 32'h0, 32'h0};

      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = 32'h0;
      m_ready = 1'b0;

      reset_and_clear("reset_state");

      for (int i = 0; i < 5; i++) run_vec(i);

      writeback_run();

      run_vec(5);

      // Reset part-way through a raster row
      begin
         int n = 0;
         build_pkt(vecs[0]);
         send_pkt("rst_raster_accept");
         while (!rch_en && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         chk(rch_en == 1'b1, "raster_start", 32'(rch_en), 32'h1);
         repeat (4) @(posedge clk);
         #1;
         reset_and_clear("rst_raster");
      end

      // Reset while a writeback beat is stalled
      begin
         int          n = 0;
         logic [15:0] held;
         m_ready = 1'b0;
         build_pkt(endv);
         send_pkt("rst_wb_accept");
         while (!m_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         chk(m_valid && m_data == 16'h6000 && !m_last, "stall_first",
             {15'h0, m_valid, m_last, m_data}, 32'h0001_6000);
         held = m_data;
         repeat (3) begin
            @(posedge clk); #1;
            chk(m_valid && m_data == held, "stall_hold",
                {15'h0, m_valid, m_data}, {15'h0, 1'b1, held});
         end
         reset_and_clear("rst_wb");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
